toom_operand_splitter: RTL and testbench

Parametrised Toom-Cook operand splitter: accepts an operand pair (X, Y) over a valid/ready handshake. It registers the pair and emits both operands as K extended limbs, LANES limbs per output beat. It sits between the operand source and the Toom evaluation stage. It generalises the fixed 1024-bit / 8-way splitter with configurable width, split degree and serialisation, flow control, and optional sign extension of the top limb.

---
 rtl/toom_pkg.sv | 15 +
 rtl/toom_limb_select.sv | 31 +++
 rtl/toom_operand_splitter.sv | 127 ++++++++++++
 tb/tb_toom_operand_splitter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/toom_pkg.sv
// rtl/toom_pkg.sv - shared defaults, limb-width helper and FSM states for the Toom operand splitter
package toom_pkg;

  localparam int DEF_OP_W  = 1024;
  localparam int DEF_K     = 8;
  localparam int DEF_LANES = 8;

  typedef enum logic {IDLE, EMIT} state_e;

  // One extra bit per limb leaves room for the sign of the top limb.
  function automatic int ext_w(input int op_w, input int k);
    return op_w / k + 1;
  endfunction

endpackage

// File: rtl/toom_limb_select.sv
// rtl/toom_limb_select.sv - picks the LANES extended limbs of one beat out of a stored operand
module toom_limb_select
  import toom_pkg::*;
#(
  parameter int OP_W  = DEF_OP_W,
  parameter int K     = DEF_K,
  parameter int LANES = DEF_LANES,
  parameter int IDX_W = 1
) (
  input  logic [OP_W-1:0]                 op_i,
  input  logic [IDX_W-1:0]                idx_i,
  input  logic                            signed_i,
  output logic [LANES*ext_w(OP_W,K)-1:0]  limbs_o
);

  localparam int LIMB_W = OP_W / K;
  localparam int EXT_W  = ext_w(OP_W, K);

  always_comb begin
    int n;
    n       = 0;
    limbs_o = '0;
    for (int i = 0; i < LANES; i++) begin
      n = int'(idx_i) * LANES + i;
      limbs_o[i*EXT_W +: LIMB_W] = LIMB_W'(op_i >> (n * LIMB_W));
      // Only the most significant limb can carry the operand sign.
      limbs_o[i*EXT_W + LIMB_W]  = (n == K - 1) && signed_i && op_i[OP_W-1];
    end
  end

endmodule

// File: rtl/toom_operand_splitter.sv
// rtl/toom_operand_splitter.sv - registers an operand pair and streams it as K extended limbs, LANES per beat
// Optional TOOM_SPLIT_SIGNED_EN adds the in_signed port for sign extension of the top limb.
module toom_operand_splitter
  import toom_pkg::*;
#(
  parameter int  OP_W  = DEF_OP_W,
  parameter int  K     = DEF_K,
  parameter int  LANES = DEF_LANES,
  localparam int EXT_W = ext_w(OP_W, K),
  localparam int BEATS = (LANES >= 1) ? K / LANES : 1,
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        X,
  input  logic [OP_W-1:0]        Y,
`ifdef TOOM_SPLIT_SIGNED_EN
  input  logic                   in_signed,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*EXT_W-1:0] out_a,
  output logic [LANES*EXT_W-1:0] out_b,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_first,
  output logic                   out_last
);

  if ((OP_W % K != 0) || (K < 2) || (LANES < 1) || (K % LANES != 0)) begin : g_bad_cfg
    $error("toom_operand_splitter: illegal OP_W/K/LANES combination");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
  logic             sgn_flag;
  logic             last_beat;
  logic             fire;

`ifdef TOOM_SPLIT_SIGNED_EN
  logic sgn_q, sgn_d;
  assign sgn_flag = sgn_q;
`else
  assign sgn_flag = 1'b0;
`endif

  assign out_valid = (state_q == EMIT);
  assign last_beat = (idx_q == IDX_W'(BEATS - 1));
  assign fire      = out_valid && out_ready;
  assign in_ready  = (state_q == IDLE) || (fire && last_beat);
  assign out_idx   = idx_q;
  assign out_first = out_valid && (idx_q == '0);
  assign out_last  = out_valid && last_beat;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
`ifdef TOOM_SPLIT_SIGNED_EN
    sgn_d   = sgn_q;
`endif
    if (fire && !last_beat) begin
      idx_d = idx_q + 1'b1;
    end else if (fire) begin
      idx_d   = '0;
      state_d = IDLE;
    end
    // Accepting overrides the return to IDLE so back-to-back pairs leave no bubble.
    if (in_valid && in_ready) begin
      state_d = EMIT;
      idx_d   = '0;
      a_d     = X;
      b_d     = Y;
`ifdef TOOM_SPLIT_SIGNED_EN
      sgn_d   = in_signed;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef TOOM_SPLIT_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
`ifdef TOOM_SPLIT_SIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  toom_limb_select #(
    .OP_W (OP_W),
    .K    (K),
    .LANES(LANES),
    .IDX_W(IDX_W)
  ) u_sel_a (
    .op_i    (a_q),
    .idx_i   (idx_q),
    .signed_i(sgn_flag),
    .limbs_o (out_a)
  );

  toom_limb_select #(
    .OP_W (OP_W),
    .K    (K),
    .LANES(LANES),
    .IDX_W(IDX_W)
  ) u_sel_b (
    .op_i    (b_q),
    .idx_i   (idx_q),
    .signed_i(sgn_flag),
    .limbs_o (out_b)
  );

endmodule

// File: tb/tb_toom_operand_splitter.sv
// tb/tb_toom_operand_splitter.sv - scoreboard bench: a 4-beat splitter under random traffic plus a single-beat default instance
module tb_toom_operand_splitter;

  localparam int OP_W  = 1024;
  localparam int K     = 8;
  localparam int L     = 2;
  localparam int LW    = OP_W / K;
  localparam int EXT   = LW + 1;
  localparam int BEATS = K / L;
`ifdef TOOM_SPLIT_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  typedef struct {
    logic [L*EXT-1:0] a;
    logic [L*EXT-1:0] b;
    int               idx;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0, in_ready;
  logic [OP_W-1:0]  opx = '0, opy = '0;
`ifdef TOOM_SPLIT_SIGNED_EN
  logic             in_signed = 1'b0;
`endif
  logic             out_valid, out_ready = 1'b0;
  logic [L*EXT-1:0] out_a, out_b;
  logic [1:0]       out_idx;
  logic             out_first, out_last;

  logic             d_valid = 1'b0, d_in_ready, d_out_valid;
  logic [OP_W-1:0]  dx = '0, dy = '0;
  logic [K*EXT-1:0] d_a, d_b;
  logic [0:0]       d_idx;
  logic             d_first, d_last;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    rdy_mode = 0;
  beat_t sb[$];

  toom_operand_splitter #(.OP_W(OP_W), .K(K), .LANES(L)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .X        (opx),
    .Y        (opy),
`ifdef TOOM_SPLIT_SIGNED_EN
    .in_signed(in_signed),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_idx  (out_idx),
    .out_first(out_first),
    .out_last (out_last)
  );

  toom_operand_splitter u_def (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (d_valid),
    .in_ready (d_in_ready),
    .X        (dx),
    .Y        (dy),
`ifdef TOOM_SPLIT_SIGNED_EN
    .in_signed(1'b0),
`endif
    .out_valid(d_out_valid),
    .out_ready(1'b1),
    .out_a    (d_a),
    .out_b    (d_b),
    .out_idx  (d_idx),
    .out_first(d_first),
    .out_last (d_last)
  );

  task automatic chk(input string name, input logic [1151:0] act, input logic [1151:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EXT-1:0] ext_limb(input logic [OP_W-1:0] op, input int n, input bit sgn);
    logic [EXT-1:0] r;
    r = {1'b0, op[n*LW +: LW]};
    if (n == K - 1 && sgn) r[LW] = op[OP_W-1];
    return r;
  endfunction

  task automatic push_pair(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y, input bit s);
    beat_t e;
    for (int j = 0; j < BEATS; j++) begin
      for (int i = 0; i < L; i++) begin
        e.a[i*EXT +: EXT] = ext_limb(x, j*L + i, s && SGN_EN);
        e.b[i*EXT +: EXT] = ext_limb(y, j*L + i, s && SGN_EN);
      end
      e.idx = j;
      sb.push_back(e);
    end
  endtask

  // Presents a pair, pushes its beats once in_ready is seen just before the edge, returns at that edge.
  task automatic send(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y, input bit s);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    opx = x;
    opy = y;
`ifdef TOOM_SPLIT_SIGNED_EN
    in_signed = s;
`endif
    forever begin
      #4;
      if (in_ready) begin
        push_pair(x, y, s);
        break;
      end
      t++;
      if (t > 200) begin
        chk("accept_timeout", 1'b0, 1'b1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic [OP_W-1:0] rand_op();
    logic [OP_W-1:0] r;
    for (int w = 0; w < OP_W / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      #1;
      chk("out_valid", out_valid, sb.size() > 0);
      case (rdy_mode)
        1:       out_ready = 1'b1;
        2:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (out_valid && sb.size() > 0) begin
        e = sb[0];
        chk("out_a", out_a, e.a);
        chk("out_b", out_b, e.b);
        chk("out_idx", out_idx, e.idx);
        chk("out_first", out_first, e.idx == 0);
        chk("out_last", out_last, e.idx == BEATS - 1);
        chk("in_ready_emit", in_ready, out_ready && (e.idx == BEATS - 1));
        if (out_ready) void'(sb.pop_front());
      end else begin
        chk("in_ready_idle", in_ready, 1'b1);
        chk("first_last_idle", {out_first, out_last}, 2'b00);
      end
    end
  end

  initial begin : main
    logic [OP_W-1:0] ones;
    logic [K*EXT-1:0] exp_a, exp_b;
    int t;
    ones = '1;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_a", out_a, '0);
    chk("rst_out_b", out_b, '0);
    chk("rst_idx", out_idx, 0);
    chk("rst_first_last", {out_first, out_last}, 2'b00);
    @(negedge clk);
    #3 rst_n = 1'b1;

    // Single-beat default instance: limb n = n+1, Y = ~X.
    for (int n = 0; n < K; n++) begin
      dx[n*LW +: LW] = LW'(n + 1);
      exp_a[n*EXT +: EXT] = {1'b0, LW'(n + 1)};
      exp_b[n*EXT +: EXT] = {1'b0, ~LW'(n + 1)};
    end
    dy = ~dx;
    @(negedge clk);
    d_valid = 1'b1;
    #4 chk("def_in_ready", d_in_ready, 1'b1);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    chk("def_valid", d_out_valid, 1'b1);
    chk("def_a", d_a, exp_a);
    chk("def_b", d_b, exp_b);
    chk("def_idx", d_idx, 0);
    chk("def_first_last", {d_first, d_last}, 2'b11);
    @(posedge clk);
    #1 chk("def_done", d_out_valid, 1'b0);

    // Known pattern and sign-extension corners, then random traffic with stalls and gaps.
    rdy_mode = 0;
    send(dx, dy, 1'b0);
    send(ones, '0, 1'b1);
    send(ones, ones, 1'b0);
    send({1'b1, (OP_W-1)'(0)}, ones, 1'b1);
    for (int p = 0; p < 40; p++) begin
      send(rand_op(), rand_op(), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) begin
        idle_cycle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    idle_cycle();

    // Long stall to exercise in_ready = 0 with a pending in_valid.
    t = 0;
    while (sb.size() > 0 && t < 400) begin @(negedge clk); t++; end
    rdy_mode = 2;
    send(rand_op(), rand_op(), 1'b1);
    @(negedge clk);
    opx = rand_op();
    opy = rand_op();
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    send(opx, opy, 1'b0);
    idle_cycle();

    // Back-to-back pairs with out_ready held high.
    t = 0;
    while (sb.size() > 0 && t < 400) begin @(negedge clk); t++; end
    rdy_mode = 1;
    for (int p = 0; p < 3; p++) send(rand_op(), rand_op(), 1'b1);
    idle_cycle();

    // Reset pulse during beat 2 drops the pair; the next pair restarts at beat 0.
    t = 0;
    while (sb.size() > 0 && t < 400) begin @(negedge clk); t++; end
    send(rand_op(), rand_op(), 1'b0);
    idle_cycle();
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_idx", out_idx, 0);
    sb.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    rdy_mode = 0;
    send(rand_op(), rand_op(), 1'b1);
    idle_cycle();

    rdy_mode = 1;
    t = 0;
    while (sb.size() > 0 && t < 400) begin @(negedge clk); t++; end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
